// File: rtl/npc_mdu_pkg.sv
// Shared M-extension definitions: decoder ALUct codes for the multiply/divide
// unit, its state encoding, and a code-classification helper.
package npc_mdu_pkg;

  localparam logic [4:0] MDU_MUL  = 5'b10001;
  localparam logic [4:0] MDU_DIV  = 5'b10010;
  localparam logic [4:0] MDU_REM  = 5'b10000;
  localparam logic [4:0] MDU_DIVU = 5'b11010;
  localparam logic [4:0] MDU_REMU = 5'b11000;

  typedef enum logic [1:0] {
    MDU_IDLE = 2'd0,
    MDU_CALC = 2'd1,
    MDU_DONE = 2'd2
  } mdu_state_e;

  localparam logic [1:0] S_IDLE = MDU_IDLE;
  localparam logic [1:0] S_CALC = MDU_CALC;
  localparam logic [1:0] S_DONE = MDU_DONE;

  function automatic logic is_mcode(input logic [4:0] ct);
    return (ct == MDU_MUL) || (ct == MDU_DIV) || (ct == MDU_REM) ||
           (ct == MDU_DIVU) || (ct == MDU_REMU);
  endfunction

endpackage

// File: rtl/mdu_iter_if.sv
// Request/response bundle between the core and the iterative multiply/divide unit.
// Handshake: request moves when in_valid && in_ready; result moves when out_valid && out_ready; flush overrides both.
interface mdu_iter_if #(
  parameter int XLEN = 64
);
  logic            in_valid;
  logic            in_ready;
  logic [4:0]      alu_ct;
  logic            is_word;
  logic [XLEN-1:0] src1;
  logic [XLEN-1:0] src2;
  logic            flush;
  logic            out_valid;
  logic            out_ready;
  logic [XLEN-1:0] result;
  logic            bad_op;

  modport master (
    output in_valid, alu_ct, is_word, src1, src2, flush, out_ready,
    input  in_ready, out_valid, result, bad_op
  );

  modport slave (
    input  in_valid, alu_ct, is_word, src1, src2, flush, out_ready,
    output in_ready, out_valid, result, bad_op
  );
endinterface

// File: rtl/mdu_datapath.sv
// Radix-2 shared datapath: shift-add multiply and restoring divide on unsigned
// magnitudes, one iteration per step through a single add/subtract unit.
module mdu_datapath #(
  parameter int XLEN = 64
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            load,
  input  logic            step,
  input  logic            mul,
  input  logic [XLEN-1:0] a,
  input  logic [XLEN-1:0] b,
  output logic [XLEN-1:0] acc_nxt,
  output logic [XLEN-1:0] quo_nxt
);
  logic [XLEN-1:0] acc_q, acc_d;
  logic [XLEN-1:0] sa_q, sa_d;
  logic [XLEN-1:0] sb_q, sb_d;
  logic [XLEN:0]   op_a, op_b, sum;
  logic            sub, ge;

  always_comb begin
    acc_d = acc_q;
    sa_d  = sa_q;
    sb_d  = sb_q;
    if (mul) begin
      op_a = {1'b0, acc_q};
      op_b = {1'b0, sa_q};
      sub  = 1'b0;
    end else begin
      op_a = {acc_q, sa_q[XLEN-1]};
      op_b = {1'b0, sb_q};
      sub  = 1'b1;
    end
    sum = op_a + (sub ? ~op_b : op_b) + {{XLEN{1'b0}}, sub};
    // Partial remainder is always below twice the divisor, so bit XLEN of the
    // difference is set exactly when the trial subtraction underflows.
    ge = ~sum[XLEN];
    if (load) begin
      acc_d = '0;
      sa_d  = a;
      sb_d  = b;
    end else if (step) begin
      if (mul) begin
        if (sb_q[0]) acc_d = sum[XLEN-1:0];
        sa_d = sa_q << 1;
        sb_d = sb_q >> 1;
      end else begin
        acc_d = ge ? sum[XLEN-1:0] : op_a[XLEN-1:0];
        sa_d  = {sa_q[XLEN-2:0], ge};
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      acc_q <= '0;
      sa_q  <= '0;
      sb_q  <= '0;
    end else begin
      acc_q <= acc_d;
      sa_q  <= sa_d;
      sb_q  <= sb_d;
    end
  end

  assign acc_nxt = acc_d;
  assign quo_nxt = sa_d;
endmodule

// File: rtl/mdu_iter.sv
// Iterative M-extension unit: decode, operand prep, fast paths, FSM and sign
// fix-up around the shared radix-2 datapath.
module mdu_iter
  import npc_mdu_pkg::*;
#(
  parameter int XLEN = 64
) (
  input  logic      clk,
  input  logic      rst,
  mdu_iter_if.slave io,
  output logic [1:0] dbg_state
);
  localparam int CW = $clog2(XLEN);
  localparam logic [XLEN-1:0] XMIN = {1'b1, {(XLEN-1){1'b0}}};
  localparam logic [XLEN-1:0] WMIN = {{(XLEN-31){1'b1}}, 31'b0};

  function automatic logic [XLEN-1:0] wfix(input logic w, input logic [XLEN-1:0] v);
    return w ? {{(XLEN-32){v[31]}}, v[31:0]} : v;
  endfunction

  logic [1:0]      state_q, state_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [XLEN-1:0] result_q, result_d;
  logic            bad_q, bad_d, word_q, word_d, mul_q, mul_d;
  logic            quo_q, quo_d, neg_q, neg_d;

  logic            is_mul, is_div, is_rem, is_divu, is_remu, is_sgn, is_dv, is_m;
  logic [XLEN-1:0] a_ext, b_ext, a_mag, b_mag, dp_a, fast_res, raw;
  logic            sgn_a, sgn_b, div0, ovf, fast, accept, dp_load, dp_step;
  logic [XLEN-1:0] acc_nxt, quo_nxt;

  always_comb begin
    is_mul  = io.alu_ct == MDU_MUL;
    is_div  = io.alu_ct == MDU_DIV;
    is_rem  = io.alu_ct == MDU_REM;
    is_divu = io.alu_ct == MDU_DIVU;
    is_remu = io.alu_ct == MDU_REMU;
    is_sgn  = is_div | is_rem;
    is_dv   = is_sgn | is_divu | is_remu;
    is_m    = is_mcode(io.alu_ct);
    if (io.is_word) begin
      a_ext = is_sgn ? {{(XLEN-32){io.src1[31]}}, io.src1[31:0]} : {{(XLEN-32){1'b0}}, io.src1[31:0]};
      b_ext = is_sgn ? {{(XLEN-32){io.src2[31]}}, io.src2[31:0]} : {{(XLEN-32){1'b0}}, io.src2[31:0]};
    end else begin
      a_ext = io.src1;
      b_ext = io.src2;
    end
    sgn_a = is_sgn & a_ext[XLEN-1];
    sgn_b = is_sgn & b_ext[XLEN-1];
    a_mag = sgn_a ? -a_ext : a_ext;
    b_mag = sgn_b ? -b_ext : b_ext;
    // Word divides left-align the dividend so 32 steps consume exactly its bits.
    dp_a  = (io.is_word && !is_mul) ? (a_mag << 32) : a_mag;
    div0  = b_ext == '0;
    ovf   = is_sgn && (a_ext == (io.is_word ? WMIN : XMIN)) && (b_ext == '1);
    fast  = !is_m || (is_dv && (div0 || ovf));
    if (!is_m)     fast_res = '0;
    else if (div0) fast_res = (is_div | is_divu) ? '1 : a_ext;
    else           fast_res = (is_div | is_divu) ? a_ext : '0;
  end

  assign io.in_ready  = (state_q == S_IDLE) && !io.flush;
  assign io.out_valid = state_q == S_DONE;
  assign io.result    = result_q;
  assign io.bad_op    = bad_q;
  assign dbg_state    = state_q;
  assign accept       = io.in_valid && io.in_ready;
  assign raw          = quo_q ? quo_nxt : acc_nxt;

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    result_d = result_q;
    bad_d    = bad_q;
    word_d   = word_q;
    mul_d    = mul_q;
    quo_d    = quo_q;
    neg_d    = neg_q;
    dp_load  = 1'b0;
    dp_step  = 1'b0;
    case (state_q)
      S_IDLE: if (accept) begin
        word_d = io.is_word;
        mul_d  = is_mul;
        quo_d  = is_div | is_divu;
        neg_d  = sgn_a ^ (is_div & sgn_b);
        bad_d  = !is_m;
        if (fast) begin
          state_d  = S_DONE;
          result_d = wfix(io.is_word, fast_res);
        end else begin
          state_d = S_CALC;
          cnt_d   = io.is_word ? CW'(31) : CW'(XLEN-1);
          dp_load = 1'b1;
        end
      end
      S_CALC: begin
        dp_step = 1'b1;
        if (cnt_q == '0) begin
          state_d  = S_DONE;
          result_d = wfix(word_q, neg_q ? -raw : raw);
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      S_DONE: if (io.out_ready) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
    if (io.flush) state_d = S_IDLE;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= S_IDLE;
      cnt_q    <= '0;
      result_q <= '0;
      bad_q    <= 1'b0;
      word_q   <= 1'b0;
      mul_q    <= 1'b0;
      quo_q    <= 1'b0;
      neg_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      result_q <= result_d;
      bad_q    <= bad_d;
      word_q   <= word_d;
      mul_q    <= mul_d;
      quo_q    <= quo_d;
      neg_q    <= neg_d;
    end
  end

  mdu_datapath #(.XLEN(XLEN)) u_dp (
    .clk     (clk),
    .rst     (rst),
    .load    (dp_load),
    .step    (dp_step),
    .mul     (mul_q),
    .a       (dp_a),
    .b       (b_mag),
    .acc_nxt (acc_nxt),
    .quo_nxt (quo_nxt)
  );
endmodule

// File: tb/tb_mdu_iter.sv
// Bench for mdu_iter: directed and random operations scored against an
// arithmetic reference model, plus back-pressure, flush and reset scenarios.
module tb_mdu_iter;
  import npc_mdu_pkg::*;

  localparam int XLEN = 64;
  localparam int W    = XLEN + 1;

  logic       clk;
  logic       rst;
  logic [1:0] dbg_state;
  int         cyc    = 0;
  int         n_chk  = 0;
  int         n_pass = 0;
  logic       rand_rdy = 1'b1;
  logic       in_out   = 1'b0;
  logic [W-1:0] exp_q[$];
  int           lat_q[$];
  int           t_q[$];

  mdu_iter_if #(.XLEN(XLEN)) io();

  mdu_iter #(.XLEN(XLEN)) dut (
    .clk       (clk),
    .rst       (rst),
    .io        (io),
    .dbg_state (dbg_state)
  );

  // clock / reset
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #600000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  // reference model
  function automatic logic [W-1:0] ref_model(input logic [4:0] ct, input logic w,
                                             input logic [63:0] a, input logic [63:0] b);
    logic [31:0] x, y, r;
    logic signed [31:0] sx, sy, sr;
    logic [63:0] p;
    logic signed [63:0] sa, sb, sp;
    x = a[31:0]; y = b[31:0]; sx = x; sy = y;
    sa = a; sb = b;
    r = '0; p = '0;
    if (!is_mcode(ct)) return {1'b1, 64'd0};
    if (w) begin
      case (ct)
        MDU_MUL:  r = x * y;
        MDU_DIVU: r = (y == 0) ? 32'hFFFF_FFFF : x / y;
        MDU_REMU: r = (y == 0) ? x : x % y;
        MDU_DIV: begin
          if (y == 0) r = 32'hFFFF_FFFF;
          else if (x == 32'h8000_0000 && y == 32'hFFFF_FFFF) r = x;
          else begin sr = sx / sy; r = sr; end
        end
        default: begin
          if (y == 0) r = x;
          else if (x == 32'h8000_0000 && y == 32'hFFFF_FFFF) r = 32'd0;
          else begin sr = sx % sy; r = sr; end
        end
      endcase
      return {1'b0, {32{r[31]}}, r};
    end
    case (ct)
      MDU_MUL:  p = a * b;
      MDU_DIVU: p = (b == 0) ? 64'hFFFF_FFFF_FFFF_FFFF : a / b;
      MDU_REMU: p = (b == 0) ? a : a % b;
      MDU_DIV: begin
        if (b == 0) p = '1;
        else if (a == 64'h8000_0000_0000_0000 && b == '1) p = a;
        else begin sp = sa / sb; p = sp; end
      end
      default: begin
        if (b == 0) p = a;
        else if (a == 64'h8000_0000_0000_0000 && b == '1) p = '0;
        else begin sp = sa % sb; p = sp; end
      end
    endcase
    return {1'b0, p};
  endfunction

  function automatic int ref_lat(input logic [4:0] ct, input logic w,
                                 input logic [63:0] a, input logic [63:0] b);
    logic zero, ovf;
    if (!is_mcode(ct)) return 1;
    if (ct == MDU_MUL) return w ? 33 : 65;
    zero = w ? (b[31:0] == 0) : (b == 0);
    ovf  = (ct == MDU_DIV || ct == MDU_REM) &&
           (w ? (a[31:0] == 32'h8000_0000 && b[31:0] == 32'hFFFF_FFFF)
              : (a == 64'h8000_0000_0000_0000 && b == '1));
    return (zero || ovf) ? 1 : (w ? 33 : 65);
  endfunction

  // driver tasks
  task automatic issue(input logic [4:0] ct, input logic w, input logic [63:0] a,
                       input logic [63:0] b, input logic push, input logic [W-1:0] exp,
                       input int lat);
    int guard = 0;
    @(negedge clk);
    io.alu_ct = ct; io.is_word = w; io.src1 = a; io.src2 = b; io.in_valid = 1'b1;
    while (!io.in_ready && guard < 300) begin
      @(negedge clk);
      guard++;
    end
    if (!io.in_ready) begin
      chk("accept_timeout", 0, 1);
      io.in_valid = 1'b0;
      return;
    end
    if (push) begin
      exp_q.push_back(exp);
      lat_q.push_back(lat);
      t_q.push_back(cyc);
    end
    @(posedge clk);
    #1 io.in_valid = 1'b0;
  endtask

  task automatic issue_model(input logic [4:0] ct, input logic w, input logic [63:0] a,
                             input logic [63:0] b);
    issue(ct, w, a, b, 1'b1, ref_model(ct, w, a, b), ref_lat(ct, w, a, b));
  endtask

  task automatic wait_drain();
    int g = 0;
    while (exp_q.size() != 0 && g < 2000) begin
      @(negedge clk);
      g++;
    end
    if (exp_q.size() != 0) begin
      chk("drain_timeout", 0, 1);
      exp_q.delete(); lat_q.delete(); t_q.delete();
    end
  endtask

  function automatic logic [63:0] rnd_val();
    case ($urandom_range(0, 7))
      0: return 64'd0;
      1: return '1;
      2: return 64'h8000_0000_0000_0000;
      3: return 64'h0000_0000_8000_0000;
      4: return 64'($urandom_range(0, 20));
      default: return {$urandom(), $urandom()};
    endcase
  endfunction

  initial begin
    forever begin
      @(posedge clk);
      #1;
      if (rand_rdy) io.out_ready = ($urandom_range(0, 3) != 0);
    end
  end

  // scoreboard monitor
  always @(negedge clk) begin
    if (rst) begin
      in_out = 1'b0;
    end else if (io.out_valid) begin
      if (exp_q.size() == 0) begin
        chk("unexpected_out_valid", 1, 0);
      end else begin
        if (!in_out) begin
          in_out = 1'b1;
          chk("latency", W'(cyc - t_q[0]), W'(lat_q[0]));
        end
        if (io.out_ready) begin
          chk("result", {io.bad_op, io.result}, exp_q[0]);
          void'(exp_q.pop_front());
          void'(lat_q.pop_front());
          void'(t_q.pop_front());
          in_out = 1'b0;
        end
      end
    end
  end

  initial begin
    logic [4:0] codes [5];
    logic [4:0] bad_codes [4];
    logic [4:0] ct;
    int seen;
    codes     = '{MDU_MUL, MDU_DIV, MDU_REM, MDU_DIVU, MDU_REMU};
    bad_codes = '{5'b00000, 5'b10011, 5'b01010, 5'b11111};
    rst = 1'b1;
    io.in_valid = 1'b0; io.alu_ct = '0; io.is_word = 1'b0;
    io.src1 = '0; io.src2 = '0; io.flush = 1'b0; io.out_ready = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_in_ready", W'(io.in_ready), 1);
    chk("rst_out_valid", W'(io.out_valid), 0);
    chk("rst_result", W'(io.result), 0);
    chk("rst_bad_op", W'(io.bad_op), 0);
    chk("rst_state", W'(dbg_state), W'(S_IDLE));
    rst = 1'b0;

    // directed cases with literal expectations
    issue(MDU_MUL,  0, 64'hFFFF_FFFF_FFFF_FFFD, 64'd7, 1, {1'b0, 64'hFFFF_FFFF_FFFF_FFEB}, 65);
    issue(MDU_DIV,  0, 64'hFFFF_FFFF_FFFF_FFF9, 64'd2, 1, {1'b0, 64'hFFFF_FFFF_FFFF_FFFD}, 65);
    issue(MDU_REM,  0, 64'hFFFF_FFFF_FFFF_FFF9, 64'd2, 1, {1'b0, 64'hFFFF_FFFF_FFFF_FFFF}, 65);
    issue(MDU_DIVU, 0, 64'd5, 64'd0, 1, {1'b0, 64'hFFFF_FFFF_FFFF_FFFF}, 1);
    issue(MDU_REMU, 0, 64'd5, 64'd0, 1, {1'b0, 64'd5}, 1);
    issue(MDU_DIV,  0, 64'h8000_0000_0000_0000, '1, 1, {1'b0, 64'h8000_0000_0000_0000}, 1);
    issue(MDU_DIV,  1, 64'h0000_0000_8000_0000, '1, 1, {1'b0, 64'hFFFF_FFFF_8000_0000}, 1);
    issue(5'b00000, 0, 64'd123, 64'd45, 1, {1'b1, 64'd0}, 1);
    wait_drain();

    // back-pressure on a word multiply
    @(negedge clk);
    rand_rdy = 1'b0;
    io.out_ready = 1'b0;
    issue(MDU_MUL, 1, 64'h0000_0000_7FFF_FFFF, 64'd2, 1, {1'b0, 64'hFFFF_FFFF_FFFF_FFFE}, 33);
    seen = 0;
    while (!io.out_valid && seen < 100) begin
      @(negedge clk);
      seen++;
    end
    chk("hold_reached_valid", W'(io.out_valid), 1);
    repeat (5) begin
      @(negedge clk);
      chk("hold_result", {io.bad_op, io.result}, {1'b0, 64'hFFFF_FFFF_FFFF_FFFE});
      chk("hold_in_ready", W'(io.in_ready), 0);
      chk("hold_out_valid", W'(io.out_valid), 1);
    end
    @(posedge clk);
    #1 io.out_ready = 1'b1;
    rand_rdy = 1'b1;
    wait_drain();

    // random operations against the model
    for (int i = 0; i < 40; i++) begin
      if ($urandom_range(0, 9) == 0) ct = bad_codes[$urandom_range(0, 3)];
      else ct = codes[$urandom_range(0, 4)];
      issue_model(ct, 1'($urandom_range(0, 1)), rnd_val(), rnd_val());
    end
    wait_drain();

    // flush in the middle of a divu
    issue(MDU_DIVU, 0, 64'd1000, 64'd7, 0, '0, 0);
    repeat (8) @(posedge clk);
    #1 io.flush = 1'b1;
    @(posedge clk);
    #1 io.flush = 1'b0;
    @(negedge clk);
    chk("flush_out_valid", W'(io.out_valid), 0);
    chk("flush_in_ready", W'(io.in_ready), 1);
    chk("flush_state", W'(dbg_state), W'(S_IDLE));
    seen = 0;
    repeat (80) begin
      @(negedge clk);
      if (io.out_valid) seen++;
    end
    chk("flush_no_result", W'(seen), 0);

    // reset in the middle of a multiply
    issue(MDU_MUL, 0, {$urandom(), $urandom()}, {$urandom(), $urandom()}, 0, '0, 0);
    repeat (5) @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    chk("midrst_in_ready", W'(io.in_ready), 1);
    chk("midrst_out_valid", W'(io.out_valid), 0);
    chk("midrst_result", W'(io.result), 0);
    chk("midrst_bad_op", W'(io.bad_op), 0);
    chk("midrst_state", W'(dbg_state), W'(S_IDLE));
    rst = 1'b0;
    seen = 0;
    repeat (80) begin
      @(negedge clk);
      if (io.out_valid) seen++;
    end
    chk("midrst_no_result", W'(seen), 0);

    // unit still usable after reset
    issue_model(MDU_DIVU, 1, 64'hFFFF_FFFF_FFFF_FFF0, 64'd3);
    wait_drain();

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule

// File: doc/mdu_iter.md
# mdu_iter

Iterative multiply/divide unit for the NPC RV64 core. It is the execution-side consumer of the M-extension control codes that the instruction decoder emits on `ALUct`: `10001` mul, `10010` div, `10000` rem, `11010` divu, `11000` remu, plus the 32-bit word variants. It replaces a combinational `*`, `/` and `%` with a shared radix-2 datapath behind a valid/ready handshake, so the core stalls until the result is returned.

## Interface
- `XLEN`, default 64: operand and result width. Word operations always use 32 bits.
- `clk` input 1: the single clock.
- `rst` input 1: synchronous, active-high reset.
- `in_valid` input 1: an operation is offered.
- `in_ready` output 1: the unit can accept an operation. High only in IDLE.
- `alu_ct` input 5: operation code, using the decoder's encodings listed above.
- `is_word` input 1: decoder `isTuncate`. Selects the 32-bit W-variant.
- `src1` input XLEN: multiplicand or dividend.
- `src2` input XLEN: multiplier or divisor.
- `flush` input 1: abort any in-flight operation.
- `out_valid` output 1: `result` is valid.
- `out_ready` input 1: the consumer takes the result.
- `result` output XLEN: the architectural result.
- `bad_op` output 1: qualifies `out_valid`. High when `alu_ct` was not an M-code.

## Operation
- **Accept.** A transfer happens when `in_valid && in_ready`. Inputs are registered on the accept edge, and the unit moves IDLE→CALC or IDLE→DONE.
- **Operand prep, word mode.** Use `src[31:0]`. Sign-extend it for signed ops (div, rem). Zero-extend it for divu, remu and mul.
- **Operand prep, W=N bits.** N is 32 when `is_word`, otherwise 64.
- **Multiply.**
  - Shift-add over N iterations, one multiplier bit per cycle.
  - Keep only the low N bits of the product. Signedness does not affect these bits.
- **Divide / remainder.**
  - Restoring division on the magnitudes, N iterations, one quotient bit per cycle.
  - Signed ops: the quotient is negated when the operand signs differ. The remainder takes the sign of the dividend.
- **Fast paths** (CALC is skipped; IDLE→DONE directly):
  - Divisor == 0: quotient = all ones (N bits), remainder = dividend.
  - Signed overflow (dividend = −2^(N−1), divisor = −1): quotient = dividend, remainder = 0.
  - `alu_ct` not an M-code: result = 0 and `bad_op` = 1.
- **Word result.** The low 32 bits are sign-extended to 64. This applies to all W ops, including divuw and remuw.
- **FSM.**
  - IDLE → CALC on accept, unless a fast path applies.
  - CALC counts down from N−1. When the count reaches 0, go to DONE.
  - DONE → IDLE on `out_ready`.
  - `flush` in any state → IDLE next cycle. `out_valid` drops and the result is discarded.
  - `flush` takes priority over a simultaneous accept or handshake.

## Timing
- **Reset values:** state = IDLE, `in_ready` = 1, `out_valid` = 0, `result` = 0, `bad_op` = 0, iteration counter = 0.
- **Latency, iterative path:** accept in cycle 0, `out_valid` high in cycle N+1.
  - 65 cycles for 64-bit ops.
  - 33 cycles for W ops.
- **Latency, fast path:** `out_valid` high in cycle 1.
- **Output stability:** `result` and `bad_op` are stable while `out_valid && !out_ready`.
- **Back-to-back issue:** a new accept is possible in the cycle after the output handshake. There is no overlap: `in_ready` stays 0 in CALC and DONE.
- **Reset mid-operation:** reset during CALC or DONE returns the unit to IDLE with all outputs at their reset values. No result is produced.

## Structure
- **Shared package `npc_mdu_pkg`:**
  - ALUct constants `MDU_MUL = 5'b10001`, `MDU_DIV = 5'b10010`, `MDU_REM = 5'b10000`, `MDU_DIVU = 5'b11010`, `MDU_REMU = 5'b11000`.
  - A state enum with IDLE, CALC, DONE.
  - The decoder references the same constants.
- **Sub-module `mdu_datapath`:** holds the accumulator, shift registers and the shared N-bit adder/subtractor, with a one-iteration step per cycle.
- **Top `mdu_iter`:** contains the FSM, counter, operand prep, fast-path detection and sign fix-up.

## Test plan
- **64-bit multiply.** mul `src1 = 0xFFFF_FFFF_FFFF_FFFD` (−3), `src2 = 7` → `result = 0xFFFF_FFFF_FFFF_FFEB` (−21), `out_valid` at cycle 65.
- **Signed divide and remainder.** div −7 / 2 → `0xFFFF_FFFF_FFFF_FFFD`; rem −7 % 2 → `0xFFFF_FFFF_FFFF_FFFF`.
- **Division by zero.** divu `src1 = 5`, `src2 = 0` → all ones, cycle 1. remu with the same operands → 5.
- **Signed overflow.** div `0x8000_0000_0000_0000` / −1 → `0x8000_0000_0000_0000`, cycle 1. divw `src1 = 0x8000_0000` / −1 → `0xFFFF_FFFF_8000_0000`.
- **Word mode and back-pressure.**
  - mulw `0x7FFF_FFFF` × 2 → `0xFFFF_FFFF_FFFF_FFFE`, at cycle 33.
  - Hold `out_ready = 0` for 5 cycles → `result` stable, `in_ready` stays 0.
- **Flush and reset.**
  - Assert `flush` at cycle 10 of a divu → IDLE next cycle, no `out_valid`.
  - Assert `rst` mid-CALC → all outputs at their reset values.
  - `alu_ct = 5'b00000` → `bad_op = 1`, `result = 0`.
